// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_BUS  = 2'b01,
    ARB_TURN = 2'b10
  } arb_state_t;

  typedef logic [1:0] grant_t;

  localparam grant_t GNT_NONE = 2'b00;
  localparam grant_t GNT_I    = 2'b01;
  localparam grant_t GNT_D    = 2'b10;

  localparam logic [31:0] DEFAULT_ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/bus_watchdog.sv
// Counts stalled bus cycles; expired is high once TIMEOUT_CYCLES stalls were seen.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT_CYCLES));

  // Saturates at the limit so a stuck slave cannot wrap the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter serialising instruction-fetch and data-access masters
// onto one Avalon-style slave, with a turnaround cycle and a stall watchdog.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ABORT_DATA     = DEFAULT_ABORT_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  grant,
  output logic        timeout_err,
  output logic        protocol_err,
  output arb_state_t  state
);

  // Handshake: a master raises its request and holds address/data until it
  // sees its waitrequest low; that single cycle is the completion cycle.
  grant_t      last_grant;
  logic        req_i, req_d, pick_d;
  logic        in_bus, wd_expired, abort, done;
  logic [31:0] bus_data;

  always_comb begin
    req_i    = i_read;
    req_d    = d_read | d_write;
    pick_d   = req_d & (~req_i | (last_grant == GNT_I));
    in_bus   = (state == ARB_BUS);
    abort    = in_bus & waitrequest & wd_expired;
    done     = in_bus & (~waitrequest | abort);
    bus_data = abort ? ABORT_DATA : readdata;
  end

  always_comb begin
    i_waitrequest = req_i & ~(grant[0] & done);
    d_waitrequest = req_d & ~(grant[1] & done);
    i_readdata    = grant[0] ? bus_data : '0;
    d_readdata    = grant[1] ? bus_data : '0;
  end

  bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (~in_bus),
    .enable  (in_bus & waitrequest),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ARB_IDLE;
      last_grant   <= GNT_D;
      grant        <= GNT_NONE;
      address      <= '0;
      read         <= 1'b0;
      write        <= 1'b0;
      writedata    <= '0;
      byteenable   <= '0;
      timeout_err  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (d_read && d_write) protocol_err <= 1'b1;
      case (state)
        ARB_IDLE: begin
          if (req_i || req_d) begin
            state <= ARB_BUS;
            if (req_i && req_d) last_grant <= pick_d ? GNT_D : GNT_I;
            if (pick_d) begin
              grant      <= GNT_D;
              address    <= d_address;
              read       <= d_read & ~d_write;
              write      <= d_write;
              writedata  <= d_writedata;
              byteenable <= d_byteenable;
            end else begin
              grant      <= GNT_I;
              address    <= i_address;
              read       <= 1'b1;
              write      <= 1'b0;
              writedata  <= '0;
              byteenable <= 4'hF;
            end
          end
        end
        ARB_BUS: begin
          // Command fields stay frozen; only the strobes drop on completion.
          if (done) begin
            read  <= 1'b0;
            write <= 1'b0;
            grant <= GNT_NONE;
            state <= ARB_TURN;
            if (abort) timeout_err <= 1'b1;
          end
        end
        ARB_TURN: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule
